// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV64I control FSM: 4 cycles per instruction (5 for load/store); run is sampled only at instruction boundaries.
// Optional feature macro ILLEGAL_TRAP_EN: an unknown opcode parks the FSM in S_TRAP until RST.
module multicycle_control_unit #(
  parameter int RESET_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [6:0]       opcode,
  output logic             WE_RF,
  output logic             WE_MEM,
  output logic [1:0]       RF_din_sel,
  output logic             ULA_din2_sel,
  output logic             load_pc,
  output logic             reset_pc,
  output logic             reset_ir,
  output logic             pc_next_sel,
  output logic             pc_adder_sel,
  output logic             busy,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       din2;
    logic [1:0] rf_sel;
    logic       we_rf;
    logic       nxt;
    logic       add;
    logic       mem;
    logic       store;
  } ctl_t;

  function automatic ctl_t decode(input logic [6:0] op);
    ctl_t c;
    c = '0;
    case (op)
      7'b0000011: begin c.din2 = 1'b1; c.rf_sel = 2'b00; c.we_rf = 1'b1; c.mem = 1'b1; end
      7'b0100011: begin c.din2 = 1'b1; c.mem = 1'b1; c.store = 1'b1; end
      7'b0010011,
      7'b0011011: begin c.din2 = 1'b1; c.rf_sel = 2'b01; c.we_rf = 1'b1; end
      7'b0110011,
      7'b0111011: begin c.rf_sel = 2'b01; c.we_rf = 1'b1; end
      7'b0110111: begin c.din2 = 1'b1; c.rf_sel = 2'b01; c.we_rf = 1'b1; end
      7'b0010111: begin c.din2 = 1'b1; c.rf_sel = 2'b11; c.we_rf = 1'b1; end
      7'b1101111: begin c.din2 = 1'b1; c.rf_sel = 2'b10; c.we_rf = 1'b1; c.nxt = 1'b1; end
      7'b1100111: begin c.din2 = 1'b1; c.rf_sel = 2'b10; c.we_rf = 1'b1; c.nxt = 1'b1; c.add = 1'b1; end
      7'b1100011: c.nxt = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [RCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctl_t             ctl_q, ctl_d, dec;
  logic             reset_q, reset_d;
  logic             busy_q, busy_d;
  logic             we_rf_q, we_rf_d;
  logic             we_mem_q, we_mem_d;
  logic             wb_q, wb_d;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q, illegal_d;
`endif

  always_comb begin
    dec       = decode(opcode);
    state_d   = state_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    ctl_d     = ctl_q;
    case (state_q)
      S_RESET: begin
        if (cnt_q == RCW'(RESET_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Selects are frozen here so they stay stable through WB.
        ctl_d   = dec;
        state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        // Every legal opcode decodes to at least one non-zero control bit.
        if (dec == '0) begin
          ctl_d   = '0;
          state_d = S_TRAP;
        end
`endif
      end
      S_EXEC:   state_d = ctl_q.mem ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB: begin
        retired_d = retired_q + 1'b1;
        ctl_d     = '0;
        state_d   = run ? S_FETCH : S_IDLE;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_RESET;
    endcase

    reset_d   = (state_d == S_RESET);
    busy_d    = (state_d != S_RESET) && (state_d != S_IDLE);
    wb_d      = (state_d == S_WB);
    we_rf_d   = wb_d && ctl_d.we_rf;
    we_mem_d  = (state_d == S_MEM) && ctl_d.store;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = (state_d == S_TRAP);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retired_q <= '0;
      ctl_q     <= '0;
      reset_q   <= 1'b1;
      busy_q    <= 1'b0;
      wb_q      <= 1'b0;
      we_rf_q   <= 1'b0;
      we_mem_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      ctl_q     <= ctl_d;
      reset_q   <= reset_d;
      busy_q    <= busy_d;
      wb_q      <= wb_d;
      we_rf_q   <= we_rf_d;
      we_mem_q  <= we_mem_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // RST overrides immediately so an aborted instruction never writes.
  assign reset_pc     = RST | reset_q;
  assign reset_ir     = RST | reset_q;
  assign WE_RF        = ~RST & we_rf_q;
  assign WE_MEM       = ~RST & we_mem_q;
  assign load_pc      = ~RST & wb_q;
  assign instr_done   = ~RST & wb_q;
  assign busy         = busy_q;
  assign retired      = retired_q;

  assign ULA_din2_sel = (state_q == S_DECODE) ? dec.din2   : ctl_q.din2;
  assign RF_din_sel   = (state_q == S_DECODE) ? dec.rf_sel : ctl_q.rf_sel;
  assign pc_next_sel  = (state_q == S_DECODE) ? dec.nxt    : ctl_q.nxt;
  assign pc_adder_sel = (state_q == S_DECODE) ? dec.add    : ctl_q.add;
`ifdef ILLEGAL_TRAP_EN
  assign illegal      = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: step-indexed instruction model checked every cycle, plus directed literal checks.
module tb_multicycle_control_unit;
  localparam int RC = 3;
  localparam int CW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic run = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc, reset_ir;
  logic pc_next_sel, pc_adder_sel, busy, instr_done;
  logic [1:0] RF_din_sel;
  logic [CW-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
  logic illegal;
`endif

  always #5 CLK = ~CLK;

  multicycle_control_unit #(.RESET_CYCLES(RC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .run(run), .opcode(opcode),
    .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel), .ULA_din2_sel(ULA_din2_sel),
    .load_pc(load_pc), .reset_pc(reset_pc), .reset_ir(reset_ir), .pc_next_sel(pc_next_sel),
    .pc_adder_sel(pc_adder_sel), .busy(busy), .instr_done(instr_done), .retired(retired)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    bit       legal;
    bit       din2;
    bit [1:0] rfs;
    bit       we;
    bit       nxt;
    bit       add;
    bit       mem;
    bit       st;
  } row_t;

  // Decode table rows straight from the instruction-class list.
  function automatic row_t spec_row(input logic [6:0] op);
    row_t r;
    r = '0;
    r.legal = 1'b1;
    case (op)
      7'b0000011:             begin r.din2 = 1; r.rfs = 2'b00; r.we = 1; r.mem = 1; end
      7'b0100011:             begin r.din2 = 1; r.mem = 1; r.st = 1; end
      7'b0010011, 7'b0011011: begin r.din2 = 1; r.rfs = 2'b01; r.we = 1; end
      7'b0110011, 7'b0111011: begin r.rfs = 2'b01; r.we = 1; end
      7'b0110111:             begin r.din2 = 1; r.rfs = 2'b01; r.we = 1; end
      7'b0010111:             begin r.din2 = 1; r.rfs = 2'b11; r.we = 1; end
      7'b1101111:             begin r.din2 = 1; r.rfs = 2'b10; r.we = 1; r.nxt = 1; end
      7'b1100111:             begin r.din2 = 1; r.rfs = 2'b10; r.we = 1; r.nxt = 1; r.add = 1; end
      7'b1100011:             r.nxt = 1;
      default:                r.legal = 1'b0;
    endcase
    return r;
  endfunction

  logic [6:0] legal_ops [11] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011,
                                 7'b0111011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011};

  typedef enum {M_UNK, M_RESETTING, M_IDLE, M_INSTR, M_TRAP} mmode_t;
  mmode_t     m_mode = M_UNK;
  int         m_left, m_k, m_len, m_ret;
  logic [6:0] m_op;
  row_t       m_row;
  logic [6:0] prog [$];

  int tests = 0;
  int fails = 0;
  int obs_busy, obs_we_rf, obs_we_mem, obs_done, obs_rp;
  logic [4:0] obs_wb_sel;
  logic obs_last_we_mem, obs_last_rp, obs_last_busy;
  logic [CW-1:0] obs_ret;
`ifdef ILLEGAL_TRAP_EN
  logic obs_illegal;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  task automatic clear_obs();
    obs_busy = 0; obs_we_rf = 0; obs_we_mem = 0; obs_done = 0; obs_rp = 0; obs_wb_sel = '0;
  endtask

  function automatic logic [6:0] rand_op();
    if ($urandom_range(7) != 0) return legal_ops[$urandom_range(10)];
    return 7'($urandom);
  endfunction

  // One clock cycle: drive at negedge, compare 1ns later, then advance the model to the next edge.
  task automatic cycle(input bit rst_i, input bit run_i);
    bit wb, memc;
    @(negedge CLK);
    RST = rst_i;
    run = run_i;
    if (m_mode == M_INSTR && m_k >= 1) opcode = m_op;
    else opcode = 7'($urandom);
    #1;
    wb   = (m_mode == M_INSTR) && (m_k == m_len - 1);
    memc = (m_mode == M_INSTR) && (m_len == 5) && (m_k == 3);
    if (rst_i || m_mode != M_UNK) begin
      chk("reset_pc", 32'(reset_pc), 32'(rst_i || m_mode == M_RESETTING));
      chk("reset_ir", 32'(reset_ir), 32'(rst_i || m_mode == M_RESETTING));
    end
    if (rst_i) begin
      chk("rst_we_rf", 32'(WE_RF), 0);
      chk("rst_we_mem", 32'(WE_MEM), 0);
      chk("rst_load_pc", 32'(load_pc), 0);
      chk("rst_done", 32'(instr_done), 0);
      if (m_mode != M_UNK) chk("rst_retired", 32'(retired), 32'(m_ret));
    end else if (m_mode != M_UNK) begin
      chk("we_rf", 32'(WE_RF), 32'(wb && m_row.we));
      chk("we_mem", 32'(WE_MEM), 32'(memc && m_row.st));
      chk("load_pc", 32'(load_pc), 32'(wb));
      chk("instr_done", 32'(instr_done), 32'(wb));
      chk("busy", 32'(busy), 32'(m_mode == M_INSTR || m_mode == M_TRAP));
      chk("retired", 32'(retired), 32'(m_ret));
      if (m_mode == M_INSTR && m_k >= 1) begin
        chk("ula_din2_sel", 32'(ULA_din2_sel), 32'(m_row.din2));
        chk("rf_din_sel", 32'(RF_din_sel), 32'(m_row.rfs));
        chk("pc_next_sel", 32'(pc_next_sel), 32'(m_row.nxt));
        chk("pc_adder_sel", 32'(pc_adder_sel), 32'(m_row.add));
      end
`ifdef ILLEGAL_TRAP_EN
      chk("illegal", 32'(illegal), 32'(m_mode == M_TRAP));
`endif
    end
    obs_busy   += int'(busy);
    obs_we_rf  += int'(WE_RF);
    obs_we_mem += int'(WE_MEM);
    obs_done   += int'(instr_done);
    obs_rp     += int'(reset_pc && !RST);
    if (instr_done) obs_wb_sel = {RF_din_sel, pc_next_sel, pc_adder_sel, load_pc};
    obs_last_we_mem = WE_MEM;
    obs_last_rp     = reset_pc;
    obs_last_busy   = busy;
    obs_ret         = retired;
`ifdef ILLEGAL_TRAP_EN
    obs_illegal = illegal;
`endif

    if (rst_i) begin
      m_mode = M_RESETTING; m_left = RC; m_ret = 0;
    end else begin
      case (m_mode)
        M_RESETTING: begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
        M_IDLE: if (run_i) begin m_mode = M_INSTR; m_k = 0; m_len = 99; end
        M_INSTR: begin
          if (m_k == m_len - 1) begin
            m_ret = (m_ret + 1) % (1 << CW);
            if (run_i) begin m_k = 0; m_len = 99; end
            else m_mode = M_IDLE;
          end else if (m_k == 0) begin
            m_op  = (prog.size() > 0) ? prog.pop_front() : rand_op();
            m_row = spec_row(m_op);
            m_len = m_row.mem ? 5 : 4;
            m_k   = 1;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            if (m_k == 1 && !m_row.legal) m_mode = M_TRAP;
            else m_k++;
`else
            m_k++;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset(input bit run_i);
    int n;
    clear_obs();
    cycle(1, run_i);
    n = 0;
    while (m_mode != M_IDLE && n < 20) begin cycle(0, run_i); n++; end
    if (m_mode != M_IDLE) timeout("reset_to_idle");
  endtask

  task automatic do_instr(input logic [6:0] op);
    int n;
    prog.push_back(op);
    cycle(0, 1);
    n = 0;
    while (m_mode == M_INSTR && n < 10) begin cycle(0, 0); n++; end
    if (m_mode == M_INSTR) timeout("instr_complete");
  endtask

  initial begin
    cycle(1, 0);
    do_reset(1);
    chk("reset_len", obs_rp, RC);
    chk("retired_after_reset", 32'(retired), 0);

    clear_obs();
    do_instr(7'b0010011);
    cycle(0, 0);
    chk("addi_cycles", obs_busy, 4);
    chk("addi_we_rf_pulses", obs_we_rf, 1);
    chk("addi_retired", 32'(obs_ret), 1);
    chk("idle_busy_after_stop", 32'(obs_last_busy), 0);

    do_reset(0);
    clear_obs();
    do_instr(7'b0100011);
    do_instr(7'b0000011);
    cycle(0, 0);
    chk("sd_ld_cycles", obs_busy, 10);
    chk("sd_ld_we_mem_pulses", obs_we_mem, 1);
    chk("sd_ld_done_pulses", obs_done, 2);
    chk("sd_ld_retired", 32'(obs_ret), 2);
    chk("ld_wb_rf_din_sel", 32'(obs_wb_sel[4:3]), 0);

    clear_obs();
    do_instr(7'b1100111);
    chk("jalr_wb_sels", 32'(obs_wb_sel), 32'h17);
    clear_obs();
    do_instr(7'b1100011);
    chk("beq_we_rf_pulses", obs_we_rf, 0);
    chk("beq_cycles", obs_busy, 4);

    clear_obs();
`ifdef ILLEGAL_TRAP_EN
    prog.push_back(7'b0000000);
    cycle(0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0);
    chk("trap_illegal", 32'(obs_illegal), 1);
    chk("trap_busy", 32'(obs_last_busy), 1);
    chk("trap_retired", 32'(obs_ret), 4);
`else
    do_instr(7'b0000000);
    cycle(0, 0);
    chk("nop_cycles", obs_busy, 4);
    chk("nop_writes", obs_we_rf + obs_we_mem, 0);
    chk("nop_retired", 32'(obs_ret), 5);
`endif

    do_reset(0);
    prog.push_back(7'b0100011);
    for (int i = 0; i < 4; i++) cycle(0, 1);
    cycle(1, 1);
    chk("rst_in_mem_we_mem", 32'(obs_last_we_mem), 0);
    cycle(0, 1);
    chk("rst_in_mem_next_reset_pc", 32'(obs_last_rp), 1);
    chk("rst_in_mem_next_busy", 32'(obs_last_busy), 0);
    chk("rst_in_mem_retired", 32'(obs_ret), 0);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(299) == 0, $urandom_range(5) != 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
